// File: rtl/instr_encoder.sv
// instr_encoder: program-loading block. Accepts one symbolic instruction per
// valid/ready handshake, packs it into a 32-bit instruction word and writes the
// words sequentially into instruction memory starting at address 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   mnem, rs, rt, rd      mnemonic and register fields
//   imm, target           immediate / branch offset, jump target
//   finish                closes the program (with a handshake or while idle)
//   mem_we/addr/wdata     instruction memory write port
//   count, full           words written, capacity reached
//   done                  program closed (terminal until rst)
//   overflow              sticky: request seen while full and not done
module instr_encoder #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic              fin_pend_q, fin_pend_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       enc_word;

  // Instruction packing: R-type (opcode 0 + funct), I-type, J-type.
  always_comb begin : encode
    enc_word = '0;
    case (mnem)
      4'd0:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};     // add
      4'd1:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};     // sub
      4'd2:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};     // and
      4'd3:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};     // or
      4'd4:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};     // slt
      4'd5:  enc_word = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08}; // jr: rt = rd = 0
      4'd6:  enc_word = {6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h10}; // mfhi: rs = rt = 0
      4'd7:  enc_word = {6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h12}; // mflo: rs = rt = 0
      4'd8:  enc_word = {6'h01, rs, rt, imm};                 // addi
      4'd9:  enc_word = {6'h02, rs, rt, imm};                 // slti
      4'd10: enc_word = {6'h03, rs, rt, imm};                 // lw
      4'd11: enc_word = {6'h04, rs, rt, imm};                 // sw
      4'd12: enc_word = {6'h05, rs, rt, imm};                 // beq
      4'd13: enc_word = {6'h06, rs, rt, imm};                 // bne
      4'd14: enc_word = {6'h07, target};                      // j
      4'd15: enc_word = {6'h08, target};                      // jal
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d     = state_q;
    fin_pend_d  = fin_pend_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && full_q) begin
          overflow_d = 1'b1;
        end
        if (in_valid && in_ready_q) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = enc_word;
          fin_pend_d  = finish;
        end else if (finish) begin
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + CNT_W'(1);
        // Address saturates at the last word; full blocks further writes.
        if (mem_addr_q != ADDR_LAST) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
        state_d    = fin_pend_q ? ST_DONE : ST_IDLE;
        fin_pend_d = 1'b0;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    full_d     = (count_d == CNT_FULL);
    done_d     = (state_d == ST_DONE);
    // Ready is registered, so it is computed from the state being entered.
    in_ready_d = (state_d == ST_IDLE) && !full_d;
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= ST_IDLE;
      fin_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_pend_q  <= fin_pend_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      full_q      <= full_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
